// File: rtl/display_scan_controller_pkg.sv
// Shared constants for the 7-segment scan controller: drive polarities, glyph patterns, FSM states.
// Glyph patterns are active-high {a,b,c,d,e,f,g,dp} with bit 7 = segment a.
package display_scan_controller_pkg;

   localparam bit COMMON_CATHODE = 1'b0;
   localparam bit COMMON_ANODE   = 1'b1;

   localparam logic [7:0] GLYPH_0    = 8'hFC;
   localparam logic [7:0] GLYPH_1    = 8'h60;
   localparam logic [7:0] GLYPH_2    = 8'hDA;
   localparam logic [7:0] GLYPH_3    = 8'hF2;
   localparam logic [7:0] GLYPH_4    = 8'h66;
   localparam logic [7:0] GLYPH_5    = 8'hB6;
   localparam logic [7:0] GLYPH_6    = 8'hBE;
   localparam logic [7:0] GLYPH_7    = 8'hE0;
   localparam logic [7:0] GLYPH_8    = 8'hFE;
   localparam logic [7:0] GLYPH_9    = 8'hF6;
   localparam logic [7:0] GLYPH_A    = 8'hEE;
   localparam logic [7:0] GLYPH_B    = 8'h3E;
   localparam logic [7:0] GLYPH_C    = 8'h9C;
   localparam logic [7:0] GLYPH_D    = 8'h7A;
   localparam logic [7:0] GLYPH_E    = 8'h9E;
   localparam logic [7:0] GLYPH_F    = 8'h8E;
   localparam logic [7:0] GLYPH_DASH = 8'h02;
   localparam logic [7:0] GLYPH_OFF  = 8'h00;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2
   } scan_state_t;

   // Hex glyph lookup; the dp bit is always clear here.
   function automatic logic [7:0] glyph_hex(input logic [3:0] nibble);
      logic [7:0] g;
      case (nibble)
         4'h0:    g = GLYPH_0;
         4'h1:    g = GLYPH_1;
         4'h2:    g = GLYPH_2;
         4'h3:    g = GLYPH_3;
         4'h4:    g = GLYPH_4;
         4'h5:    g = GLYPH_5;
         4'h6:    g = GLYPH_6;
         4'h7:    g = GLYPH_7;
         4'h8:    g = GLYPH_8;
         4'h9:    g = GLYPH_9;
         4'hA:    g = GLYPH_A;
         4'hB:    g = GLYPH_B;
         4'hC:    g = GLYPH_C;
         4'hD:    g = GLYPH_D;
         4'hE:    g = GLYPH_E;
         default: g = GLYPH_F;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/display_scan_controller_glyph.sv
// Combinational nibble + dp + blank to active-high segment pattern.
// With HEX_MODE=0, nibbles above 9 render as a dash.
module seg7_glyph_decoder
   import display_scan_controller_pkg::*;
#(
   parameter bit HEX_MODE = 1'b1
) (
   input  logic [3:0] nibble,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] pattern_c
);

   always_comb begin
      pattern_c = GLYPH_OFF;
      if (!blank) begin
         if (!HEX_MODE && (nibble > 4'd9)) begin
            pattern_c = GLYPH_DASH;
         end else begin
            pattern_c = glyph_hex(nibble);
         end
         pattern_c[0] = pattern_c[0] | dp;
      end
   end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed 7-segment scan controller: shadowed value load, per-digit dwell and blank gap,
// registered segment bus and one-hot digit enables with configurable drive polarity.
module display_scan_controller
   import display_scan_controller_pkg::*;
#(
   parameter int unsigned NUM_DIGITS         = 4,
   parameter int unsigned SCAN_DIV           = 50000,
   parameter int unsigned BLANK_CYCLES       = 500,
   parameter bit          SEG_ACTIVE_LOW     = COMMON_CATHODE,
   parameter bit          DIG_ACTIVE_LOW     = 1'b0,
   parameter bit          HEX_MODE           = 1'b1,
   parameter bit          LEADING_ZERO_BLANK = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   input  logic [NUM_DIGITS-1:0]   load_dp,
   output logic [7:0]              seg,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    frame_done,
   output logic                    over_range
);

   localparam int unsigned DATA_W    = 4 * NUM_DIGITS;
   localparam int unsigned IDX_W     = $clog2(NUM_DIGITS);
   localparam int unsigned PRESC_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
   localparam int unsigned PRESC_W   = $clog2(PRESC_MAX + 1);

   localparam logic [PRESC_W-1:0]    SHOW_LAST = PRESC_W'(SCAN_DIV - 32'd1);
   localparam logic [PRESC_W-1:0]    GAP_LAST  = PRESC_W'((BLANK_CYCLES == 32'd0) ? 32'd0 : BLANK_CYCLES - 32'd1);
   localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 32'd1);
   localparam bit                    NO_GAP    = (BLANK_CYCLES == 32'd0);
   localparam logic [7:0]            SEG_OFF   = {8{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] DIG_OFF   = {NUM_DIGITS{DIG_ACTIVE_LOW}};

   scan_state_t             state;
   logic [PRESC_W-1:0]      presc;
   logic [IDX_W-1:0]        idx;
   logic [DATA_W-1:0]       active_data;
   logic [DATA_W-1:0]       shadow_data;
   logic [NUM_DIGITS-1:0]   active_dp;
   logic [NUM_DIGITS-1:0]   shadow_dp;

   logic                    advance_c;
   logic                    frame_start_c;
   logic                    transfer_c;
   logic [IDX_W-1:0]        next_idx_c;
   logic [3:0]              cur_nibble_c;
   logic                    cur_dp_c;
   logic                    upper_zero_c;
   logic                    any_over_c;
   logic                    blank_c;
   logic [7:0]              pattern_c;
   logic [NUM_DIGITS-1:0]   onehot_c;

   // Scan sequencing decodes: digit advance and frame boundary.
   always_comb begin
      advance_c     = ((state == ST_SHOW) && (presc == SHOW_LAST) && NO_GAP) ||
                      ((state == ST_GAP)  && (presc == GAP_LAST));
      frame_start_c = en && ((state == ST_OFF) || (advance_c && (idx == LAST_IDX)));
      next_idx_c    = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      transfer_c    = load_valid && load_ready;
   end

   // Current digit selection, leading-zero detection and range check over the active value.
   always_comb begin
      cur_nibble_c = 4'h0;
      cur_dp_c     = 1'b0;
      upper_zero_c = 1'b1;
      any_over_c   = 1'b0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (idx == IDX_W'(i)) begin
            cur_nibble_c = active_data[4*i +: 4];
            cur_dp_c     = active_dp[i];
         end
         if ((IDX_W'(i) >= idx) && (active_data[4*i +: 4] != 4'h0)) begin
            upper_zero_c = 1'b0;
         end
         if (active_data[4*i +: 4] > 4'd9) begin
            any_over_c = 1'b1;
         end
      end
      blank_c  = LEADING_ZERO_BLANK && (idx != '0) && upper_zero_c;
      onehot_c = NUM_DIGITS'(1) << idx;
   end

   seg7_glyph_decoder #(
      .HEX_MODE (HEX_MODE)
   ) u_glyph (
      .nibble    (cur_nibble_c),
      .dp        (cur_dp_c),
      .blank     (blank_c),
      .pattern_c (pattern_c)
   );

   // FSM, value shadowing and registered pin drive. load_ready low means a value is pending.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_OFF;
         presc       <= '0;
         idx         <= '0;
         active_data <= '0;
         active_dp   <= '0;
         shadow_data <= '0;
         shadow_dp   <= '0;
         load_ready  <= 1'b1;
         seg         <= SEG_OFF;
         digit_sel   <= DIG_OFF;
         frame_done  <= 1'b0;
         over_range  <= 1'b0;
      end else begin
         frame_done <= frame_start_c;
         over_range <= !HEX_MODE && any_over_c;

         if (state == ST_SHOW) begin
            seg       <= pattern_c ^ SEG_OFF;
            digit_sel <= onehot_c ^ DIG_OFF;
         end else begin
            seg       <= SEG_OFF;
            digit_sel <= DIG_OFF;
         end

         if (frame_start_c && !load_ready) begin
            active_data <= shadow_data;
            active_dp   <= shadow_dp;
            load_ready  <= 1'b1;
         end else if (transfer_c) begin
            shadow_data <= load_data;
            shadow_dp   <= load_dp;
            load_ready  <= 1'b0;
         end

         if (!en) begin
            state <= ST_OFF;
            presc <= '0;
            idx   <= '0;
         end else begin
            case (state)
               ST_OFF: begin
                  state <= ST_SHOW;
                  presc <= '0;
                  idx   <= '0;
               end
               ST_SHOW: begin
                  if (presc == SHOW_LAST) begin
                     presc <= '0;
                     if (NO_GAP) begin
                        idx <= next_idx_c;
                     end else begin
                        state <= ST_GAP;
                     end
                  end else begin
                     presc <= presc + PRESC_W'(1);
                  end
               end
               ST_GAP: begin
                  if (presc == GAP_LAST) begin
                     presc <= '0;
                     state <= ST_SHOW;
                     idx   <= next_idx_c;
                  end else begin
                     presc <= presc + PRESC_W'(1);
                  end
               end
               default: begin
                  state <= ST_OFF;
                  presc <= '0;
                  idx   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller: two configurations share stimulus, a frame-timeline
// reference model predicts every output cycle, and a monitor pops and compares.
module tb_display_scan_controller;

   localparam int ND = 4;
   localparam int SCAN_T  [2] = '{4, 3};
   localparam int BLANK_T [2] = '{2, 0};
   localparam int SEGAL_T [2] = '{0, 1};
   localparam int DIGAL_T [2] = '{0, 1};
   localparam int HEX_T   [2] = '{1, 0};
   localparam int LZB_T   [2] = '{0, 1};
   localparam logic [7:0] GLYPHS [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                          8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

   typedef struct packed {
      logic [7:0] seg;
      logic [3:0] dsel;
      logic       fd;
      logic       rdy;
      logic       ovr;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             load_valid = 1'b0;
   logic [15:0]      load_data = '0;
   logic [3:0]       load_dp = '0;
   logic [1:0]       load_ready;
   logic [1:0][7:0]  seg_o;
   logic [1:0][3:0]  dsel_o;
   logic [1:0]       frame_done;
   logic [1:0]       over_range;

   exp_t q0[$];
   exp_t q1[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   n_fail = 0;

   int          t      [2];
   logic [15:0] act_d  [2];
   logic [15:0] sh_d   [2];
   logic [3:0]  act_dp [2];
   logic [3:0]  sh_dp  [2];
   bit          pend   [2];

   always #5 clk = ~clk;

   display_scan_controller #(
      .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b0),
      .DIG_ACTIVE_LOW(1'b0), .HEX_MODE(1'b1), .LEADING_ZERO_BLANK(1'b0)
   ) u_dut_a (
      .clk(clk), .reset(rst), .en(en), .load_valid(load_valid), .load_ready(load_ready[0]),
      .load_data(load_data), .load_dp(load_dp), .seg(seg_o[0]), .digit_sel(dsel_o[0]),
      .frame_done(frame_done[0]), .over_range(over_range[0])
   );

   display_scan_controller #(
      .NUM_DIGITS(4), .SCAN_DIV(3), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b1),
      .DIG_ACTIVE_LOW(1'b1), .HEX_MODE(1'b0), .LEADING_ZERO_BLANK(1'b1)
   ) u_dut_b (
      .clk(clk), .reset(rst), .en(en), .load_valid(load_valid), .load_ready(load_ready[1]),
      .load_data(load_data), .load_dp(load_dp), .seg(seg_o[1]), .digit_sel(dsel_o[1]),
      .frame_done(frame_done[1]), .over_range(over_range[1])
   );

   // Pin values while the display is dark, by configuration.
   function automatic exp_t dark(input int l);
      exp_t e;
      e      = '0;
      e.seg  = (SEGAL_T[l] != 0) ? 8'hFF : 8'h00;
      e.dsel = (DIGAL_T[l] != 0) ? 4'hF : 4'h0;
      return e;
   endfunction

   // Expected pins for a point tt cycles into the scan timeline (tt<0: display off).
   function automatic exp_t scan_pins(input int l, input int tt, input logic [15:0] a, input logic [3:0] dp);
      exp_t       e;
      logic [7:0] pat;
      logic [3:0] sel;
      logic [3:0] nib;
      int         per;
      int         p;
      int         d;
      e   = dark(l);
      pat = 8'h00;
      sel = 4'h0;
      per = SCAN_T[l] + BLANK_T[l];
      if (tt >= 0) begin
         p = tt % (ND * per);
         d = p / per;
         if ((p % per) < SCAN_T[l]) begin
            sel = 4'(1 << d);
            nib = 4'(a >> (4 * d));
            if ((LZB_T[l] != 0) && (d > 0) && ((a >> (4 * d)) == 16'h0)) begin
               pat = 8'h00;
            end else begin
               pat    = ((HEX_T[l] == 0) && (nib > 4'd9)) ? 8'h02 : GLYPHS[nib];
               pat[0] = pat[0] | dp[d];
            end
            e.seg  = (SEGAL_T[l] != 0) ? ~pat : pat;
            e.dsel = (DIGAL_T[l] != 0) ? ~sel : sel;
         end
      end
      return e;
   endfunction

   function automatic logic any_over(input logic [15:0] a);
      logic r;
      r = 1'b0;
      for (int k = 0; k < ND; k++) begin
         if (4'(a >> (4 * k)) > 4'd9) r = 1'b1;
      end
      return r;
   endfunction

   // Reference model: steps one scan timeline per configuration at each rising edge.
   initial begin
      exp_t e;
      int   tn;
      bit   bnd;
      forever begin
         @(posedge clk);
         if (rst) begin
            for (int l = 0; l < 2; l++) begin
               t[l] = -1; act_d[l] = '0; sh_d[l] = '0; act_dp[l] = '0; sh_dp[l] = '0; pend[l] = 1'b0;
            end
            q0.delete();
            q1.delete();
         end else begin
            for (int l = 0; l < 2; l++) begin
               e     = scan_pins(l, t[l], act_d[l], act_dp[l]);
               e.ovr = (HEX_T[l] == 0) && any_over(act_d[l]);
               tn    = en ? ((t[l] < 0) ? 0 : t[l] + 1) : -1;
               bnd   = (tn >= 0) && ((tn % (ND * (SCAN_T[l] + BLANK_T[l]))) == 0);
               e.fd  = bnd;
               if (bnd && pend[l]) begin
                  act_d[l] = sh_d[l]; act_dp[l] = sh_dp[l]; pend[l] = 1'b0;
               end else if (load_valid && !pend[l]) begin
                  sh_d[l] = load_data; sh_dp[l] = load_dp; pend[l] = 1'b1;
               end
               e.rdy = !pend[l];
               t[l]  = tn;
               if (l == 0) q0.push_back(e);
               else        q1.push_back(e);
            end
         end
      end
   end

   task automatic chk(input string name, input int l, input logic [7:0] got, input logic [7:0] want);
      n_checks++;
      if (got === want) begin
         n_pass++;
      end else begin
         n_fail++;
         if (n_fail <= 30) $display("FAIL %s lane%0d @%0t: got %02h expected %02h", name, l, $time, got, want);
      end
   endtask

   task automatic cmp_lane(input int l, input exp_t e);
      chk("seg", l, seg_o[l], e.seg);
      chk("digit_sel", l, 8'(dsel_o[l]), 8'(e.dsel));
      chk("frame_done", l, 8'(frame_done[l]), 8'(e.fd));
      chk("load_ready", l, 8'(load_ready[l]), 8'(e.rdy));
      chk("over_range", l, 8'(over_range[l]), 8'(e.ovr));
   endtask

   // Monitor: reset values immediately on reset assertion, otherwise pop one expectation per lane per cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or posedge rst);
         if (rst) begin
            #1;
            for (int l = 0; l < 2; l++) begin
               e     = dark(l);
               e.rdy = 1'b1;
               cmp_lane(l, e);
            end
         end else begin
            for (int l = 0; l < 2; l++) begin
               if (((l == 0) ? q0.size() : q1.size()) == 0) begin
                  chk("scoreboard_empty", l, 8'd0, 8'd1);
               end else begin
                  e = (l == 0) ? q0.pop_front() : q1.pop_front();
                  cmp_lane(l, e);
               end
            end
         end
      end
   end

   function automatic logic [15:0] rand_val();
      logic [15:0] v;
      v = '0;
      for (int k = 0; k < ND; k++) begin
         v = v | (16'(($urandom_range(0, 4) < 2) ? 0 : $urandom_range(0, 15)) << (4 * k));
      end
      return v;
   endfunction

   task automatic pulse_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      load_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
   endtask

   localparam logic [15:0] DIR_VAL [5] = '{16'h1234, 16'h0070, 16'h00A5, 16'h1111, 16'h2222};
   localparam logic [3:0]  DIR_DP  [5] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0};

   initial begin
      en = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      repeat (60) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         #2;
         load_valid = 1'b1;
         load_data  = DIR_VAL[k];
         load_dp    = DIR_DP[k];
         repeat (60) @(negedge clk);
      end
      // Reset while a value is pending: it must be discarded.
      #2 load_data = 16'h4321;
      @(negedge clk);
      #2 rst = 1'b1;
      load_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      repeat (40) @(negedge clk);
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         #2;
         load_valid = ($urandom_range(0, 9) < 6);
         load_data  = rand_val();
         load_dp    = 4'($urandom_range(0, 15));
         if (en && ($urandom_range(0, 199) == 0)) en = 1'b0;
         else if (!en && ($urandom_range(0, 3) == 0)) en = 1'b1;
         if ($urandom_range(0, 799) == 0) pulse_reset();
      end
      @(negedge clk);
      #2 load_valid = 1'b0;
      en = 1'b1;
      repeat (10) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
